// File: rtl/hybrid_control_pipelined.sv
// Hybrid sigma controller: surface signs via a 3-stage multiply pipeline, debounce, dwell-gated FSM, per-leg dead time.
// States: P=00 sigma +1 | Z1=01 sigma 0 | N=10 sigma -1 | Z2=11 sigma 0
module hybrid_control_pipelined #(
  parameter int DW        = 14,
  parameter int CW        = 16,
  parameter int MUW       = 16,
  parameter int MU_Z1     = 86,
  parameter int MU_Z2     = 90,
  parameter int DEBOUNCE  = 2,
  parameter int MIN_DWELL = 100,
  parameter int DEAD_TIME = 8
) (
  input  logic                 i_clock,
  input  logic                 i_RESET,
  input  logic                 i_enable,
  input  logic                 i_mode,
  input  logic signed [DW-1:0] i_vC,
  input  logic signed [DW-1:0] i_iC,
  input  logic signed [CW-1:0] i_sin_a,
  input  logic signed [CW-1:0] i_cos_a,
  input  logic signed [CW-1:0] i_sin_b,
  input  logic signed [CW-1:0] i_cos_b,
  output logic [3:0]           o_MOSFET,
  output logic [1:0]           o_sigma,
  output logic [1:0]           o_state,
  output logic                 o_jump,
  output logic [7:0]           o_debug
);

  localparam int XW  = DW + MUW + 1;
  localparam int PW  = XW + CW;
  localparam int SW  = DW + MUW + CW + 2;
  localparam int DBW = $clog2(DEBOUNCE + 1);
  localparam int DWW = (MIN_DWELL < 1) ? 1 : $clog2(MIN_DWELL + 1);
  localparam int DTW = (DEAD_TIME < 1) ? 1 : $clog2(DEAD_TIME + 1);

  localparam logic signed [MUW:0]    MUZ1_S  = {1'b0, MUW'(MU_Z1)};
  localparam logic signed [MUW:0]    MUZ2_S  = {1'b0, MUW'(MU_Z2)};
  localparam logic [DBW-1:0]         DB_LIM  = DBW'(DEBOUNCE - 1);
  localparam logic [DTW-1:0]         DT_FULL = DTW'(DEAD_TIME);
  // The edge that detects a target change is itself the first off cycle.
  localparam logic [DTW-1:0]         DT_RST  = DTW'((DEAD_TIME > 0) ? DEAD_TIME - 1 : 0);
  localparam logic signed [SW-1:0]   S_ZERO  = '0;

  typedef enum logic [1:0] {ST_P = 2'b00, ST_Z1 = 2'b01, ST_N = 2'b10, ST_Z2 = 2'b11} state_t;

  logic signed [XW-1:0] x1_d, x2_d, x1_q, x2_q;
  logic signed [PW-1:0] p_d [4];
  logic signed [PW-1:0] p_q [4];
  logic signed [SW-1:0] s_d [2];
  logic signed [SW-1:0] s_q [2];
  logic [1:0]           neg_raw, db_q;
  logic [DBW-1:0]       db_cnt_q [2];

  assign x1_d   = XW'(i_vC) * XW'(MUZ1_S);
  assign x2_d   = XW'(i_iC) * XW'(MUZ2_S);
  assign p_d[0] = PW'(x1_q) * PW'(i_sin_b);
  assign p_d[1] = PW'(x2_q) * PW'(i_cos_b);
  assign p_d[2] = PW'(x1_q) * PW'(i_sin_a);
  assign p_d[3] = PW'(x2_q) * PW'(i_cos_a);
  assign s_d[0] = SW'(p_q[0]) - SW'(p_q[1]);
  assign s_d[1] = SW'(p_q[2]) - SW'(p_q[3]);

  assign neg_raw = {s_q[1] < S_ZERO, s_q[0] < S_ZERO};

  always_ff @(posedge i_clock) begin
    if (!i_RESET) begin
      x1_q <= '0;
      x2_q <= '0;
      for (int k = 0; k < 4; k++) p_q[k] <= '0;
      for (int k = 0; k < 2; k++) s_q[k] <= '0;
    end else begin
      x1_q <= x1_d;
      x2_q <= x2_d;
      for (int k = 0; k < 4; k++) p_q[k] <= p_d[k];
      for (int k = 0; k < 2; k++) s_q[k] <= s_d[k];
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_RESET) begin
      db_q <= '0;
      for (int k = 0; k < 2; k++) db_cnt_q[k] <= '0;
    end else if (i_enable) begin
      for (int k = 0; k < 2; k++) begin
        if (neg_raw[k] == db_q[k]) begin
          db_cnt_q[k] <= '0;
        end else if (db_cnt_q[k] >= DB_LIM) begin
          db_q[k]     <= neg_raw[k];
          db_cnt_q[k] <= '0;
        end else begin
          db_cnt_q[k] <= db_cnt_q[k] + 1'b1;
        end
      end
    end
  end

  state_t         state_q, state_d;
  logic           cond_ok;
  logic [DWW-1:0] dwell_q;
  logic           jump_q;
  logic [1:0]     sigma_q;

  function automatic logic [1:0] sigma_of(input state_t s);
    case (s)
      ST_P:    sigma_of = 2'b01;
      ST_N:    sigma_of = 2'b11;
      default: sigma_of = 2'b00;
    endcase
  endfunction

  always_comb begin
    cond_ok = 1'b0;
    state_d = state_q;
    unique case (state_q)
      ST_P:  if (!db_q[0])            begin cond_ok = 1'b1; state_d = i_mode ? ST_N : ST_Z1; end
      ST_Z1: if (!db_q[0] && !db_q[1]) begin cond_ok = 1'b1; state_d = ST_N; end
      ST_N:  if (db_q[0])             begin cond_ok = 1'b1; state_d = i_mode ? ST_P : ST_Z2; end
      ST_Z2: if (db_q[0] && db_q[1])  begin cond_ok = 1'b1; state_d = ST_P; end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_RESET) begin
      state_q <= ST_N;
      dwell_q <= '0;
      jump_q  <= 1'b0;
      sigma_q <= 2'b11;
    end else begin
      jump_q <= 1'b0;
      if (i_enable) begin
        if (cond_ok && dwell_q == '0) begin
          state_q <= state_d;
          sigma_q <= sigma_of(state_d);
          dwell_q <= DWW'(MIN_DWELL);
          jump_q  <= 1'b1;
        end else if (dwell_q != '0) begin
          dwell_q <= dwell_q - 1'b1;
        end
      end
    end
  end

  // Leg 0 = A as {M2,M0}, leg 1 = B as {M3,M1}.
  logic [1:0]     tgt_d [2];
  logic [1:0]     tgt_q [2];
  logic [1:0]     leg_q [2];
  logic [DTW-1:0] dcnt_q [2];

  assign tgt_d[0] = (state_q == ST_N) ? 2'b10 : 2'b01;
  assign tgt_d[1] = (state_q == ST_P) ? 2'b10 : 2'b01;

  always_ff @(posedge i_clock) begin
    if (!i_RESET) begin
      tgt_q[0] <= 2'b10;
      tgt_q[1] <= 2'b01;
      for (int l = 0; l < 2; l++) begin
        leg_q[l]  <= 2'b00;
        dcnt_q[l] <= DT_FULL;
      end
    end else if (!i_enable) begin
      for (int l = 0; l < 2; l++) begin
        tgt_q[l]  <= tgt_d[l];
        leg_q[l]  <= 2'b00;
        dcnt_q[l] <= DT_FULL;
      end
    end else begin
      for (int l = 0; l < 2; l++) begin
        tgt_q[l] <= tgt_d[l];
        if (tgt_d[l] != tgt_q[l]) begin
          dcnt_q[l] <= DT_RST;
          leg_q[l]  <= (DEAD_TIME == 0) ? tgt_d[l] : 2'b00;
        end else if (dcnt_q[l] != '0) begin
          dcnt_q[l] <= dcnt_q[l] - 1'b1;
          leg_q[l]  <= 2'b00;
        end else begin
          leg_q[l]  <= tgt_d[l];
        end
      end
    end
  end

  assign o_MOSFET = {leg_q[1][1], leg_q[0][1], leg_q[1][0], leg_q[0][0]};
  assign o_sigma  = sigma_q;
  assign o_state  = state_q;
  assign o_jump   = jump_q;
  assign o_debug  = {neg_raw[1], neg_raw[0], db_q[1], db_q[0], dwell_q != '0,
                     leg_q[0] == 2'b00, leg_q[1] == 2'b00, i_mode};

endmodule
